// File: rtl/adder_frame_ctrl.sv
// rtl/adder_frame_ctrl.sv - frame sequencer for the 16-input pipelined signed adder tree
module adder_frame_ctrl #(
  parameter int WIDTH   = 25,
  parameter int N_WORDS = 16,
  parameter int LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [N_WORDS*WIDTH-1:0]   word_bus,
  input  logic [WIDTH-1:0]           add_res,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_WORDS):0]   out_count,
  output logic [15:0]                frame_cnt
);

  localparam int PW = $clog2(N_WORDS);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] words [N_WORDS];
  logic [PW-1:0]    wr_ptr;
  logic [LW-1:0]    lat_cnt;
  logic [CW-1:0]    cnt_latch;
  logic             accept;
  logic             close;

  assign accept = in_valid & in_ready;
  assign close  = accept & (in_last | (wr_ptr == PW'(N_WORDS - 1)));

  always_comb begin
    word_bus = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      word_bus[i*WIDTH +: WIDTH] = words[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FILL;
      for (int i = 0; i < N_WORDS; i++) words[i] <= '0;
      wr_ptr    <= '0;
      lat_cnt   <= '0;
      cnt_latch <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            words[wr_ptr] <= in_data;
            wr_ptr        <= wr_ptr + PW'(1);
            if (close) begin
              state     <= S_WAIT;
              in_ready  <= 1'b0;
              lat_cnt   <= LW'(LATENCY);
              cnt_latch <= CW'(wr_ptr) + CW'(1);
            end
          end
        end
        // The buffer is frozen here, so ADD_RES reflects this frame once the count expires.
        S_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LW'(1);
          end else begin
            out_data  <= add_res;
            out_count <= cnt_latch;
            out_valid <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            for (int i = 0; i < N_WORDS; i++) words[i] <= '0;
            wr_ptr    <= '0;
            in_ready  <= 1'b1;
            state     <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_frame_ctrl.sv
// tb/tb_adder_frame_ctrl.sv - scoreboard bench for adder_frame_ctrl with a behavioural adder tree
module tb_adder_frame_ctrl;

  logic          clk;
  logic          rst;
  logic [24:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [399:0]  word_bus;
  logic [24:0]   add_res;
  logic [24:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_count;
  logic [15:0]   frame_cnt;

  adder_frame_ctrl dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .word_bus(word_bus), .add_res(add_res), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Four-stage adder tree stand-in: full sum registered, then three delay stages.
  logic [24:0] bus_sum, s1, s2, s3;
  always_comb begin
    bus_sum = '0;
    for (int i = 0; i < 16; i++) bus_sum = bus_sum + word_bus[i*25 +: 25];
  end
  always @(posedge clk) begin
    s1      <= bus_sum;
    s2      <= s1;
    s3      <= s2;
    add_res <= s3;
  end

  typedef struct {
    logic [24:0] sum;
    logic [4:0]  cnt;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_fc = '0;
  logic [24:0] frm [16];
  bit          rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 2ns after the falling edge, pops on every handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.sum);
        chk("out_count", 25'(out_count), 25'(e.cnt));
        chk("frame_cnt", 25'(frame_cnt), 25'(e.fc));
      end
    end
  end

  always @(negedge clk) if (rdy_rand) out_ready = 1'($urandom_range(0, 1));

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_word(input logic [24:0] d, input bit l);
    int k = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps, input bit last15, input bit push,
                            input logic [24:0] esum);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_last  = 1'b1;
          in_data  = 25'($urandom);
          @(negedge clk);
        end
      end
      send_word(frm[i], (i == n - 1) && (n < 16 || last15));
    end
    if (push) begin
      exp_fc++;
      sb.push_back('{esum, 5'(n), exp_fc});
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic fill_const(input logic [24:0] v);
    for (int i = 0; i < 16; i++) frm[i] = v;
  endtask

  initial begin
    int          k;
    bit          bad;
    logic [24:0] sum;
    int          n;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 25'(in_ready), 25'd1);
    chk("rst_out_valid", 25'(out_valid), 25'd0);
    chk("rst_frame_cnt", 25'(frame_cnt), 25'd0);
    chk("rst_out_data", out_data, 25'd0);
    chk("rst_word_bus", 25'(|word_bus), 25'd0);
    rst = 1'b0;

    // 1) Full frame 1..16 -> 136, OUT_VALID 5 edges after the closing accept
    for (int i = 0; i < 16; i++) frm[i] = 25'(i + 1);
    send_frame(16, 0, 0, 1, 25'd136);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency_edges", 25'(k), 25'd5);
    drain();

    // 2) Negative and wrapping sums
    fill_const(25'h1FFFFFF);
    send_frame(16, 0, 0, 1, 25'h1FFFFF0);
    drain();
    fill_const(25'h0FFFFFF);
    send_frame(16, 0, 0, 1, 25'h1FFFFF0);
    drain();

    // 3) Full frame of 100s, then short frame 5,6,7 must see zero-filled slots
    fill_const(25'd100);
    send_frame(16, 0, 0, 1, 25'd1600);
    drain();
    frm[0] = 25'd5; frm[1] = 25'd6; frm[2] = 25'd7;
    send_frame(3, 0, 0, 1, 25'd18);
    drain();

    // 4) Back-pressure on the result port with the source pushing throughout
    out_ready = 1'b0;
    fill_const(25'd3);
    send_frame(16, 0, 0, 1, 25'd48);
    in_data = 25'd9; in_last = 1'b0; in_valid = 1'b1;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("hold_valid_rise", 25'(out_valid), 25'd1);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 25'd48) bad = 1'b1;
    end
    chk("hold_stable", 25'(bad), 25'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_valid", 25'(out_valid), 25'd0);
    chk("handoff_in_ready", 25'(in_ready), 25'd1);
    chk("handoff_no_accept", 25'(|word_bus), 25'd0);
    send_word(25'd9, 1'b0);
    send_word(25'd1, 1'b1);
    exp_fc++;
    sb.push_back('{25'd10, 5'd2, exp_fc});
    out_ready = 1'b1;
    drain();

    // 5) Reset while waiting on the tree with LAT_CNT at 2
    fill_const(25'd7);
    send_frame(16, 0, 0, 0, 25'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_fc = '0;
    chk("rst_wait_in_ready", 25'(in_ready), 25'd1);
    chk("rst_wait_frame_cnt", 25'(frame_cnt), 25'd0);
    bad = 1'b0;
    repeat (8) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("rst_wait_no_valid", 25'(bad), 25'd0);
    fill_const(25'd2);
    send_frame(16, 0, 0, 1, 25'd32);
    drain();

    // 6) 1000 random frames with gaps on both sides, from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_fc = '0;
    rdy_rand = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      n   = $urandom_range(1, 16);
      sum = '0;
      for (int i = 0; i < n; i++) begin
        frm[i] = 25'($urandom);
        sum    = sum + frm[i];
      end
      send_frame(n, 1, 1'($urandom_range(0, 1)), 1, sum);
    end
    @(negedge clk);
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("final_frame_cnt", 25'(frame_cnt), 25'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
